// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  count, count_next;
   logic [31:0]       a_lat, b_lat;
   logic [1:0]        op_lat;
   logic              load, commit, write_hi, write_lo;
   logic [63:0]       result;
   logic signed [31:0] a_s, b_s;

   assign a_s  = $signed(a_lat);
   assign b_s  = $signed(b_lat);
   assign Busy = (state == RUN);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Requests are only honoured while idle; anything arriving during a run is dropped.
   always_comb begin
      state_next = state;
      count_next = count;
      load       = 1'b0;
      commit     = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               case (Op)
                  3'd0, 3'd1: begin
                     load       = 1'b1;
                     count_next = CNT_W'(MULT_CYCLES);
                     state_next = RUN;
                  end
                  3'd2, 3'd3: begin
                     load       = 1'b1;
                     count_next = CNT_W'(DIV_CYCLES);
                     state_next = RUN;
                  end
                  3'd4:    write_hi = 1'b1;
                  3'd5:    write_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            count_next = count - 1'b1;
            if (count == CNT_W'(1)) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Divide-by-zero and the single signed overflow case are resolved explicitly.
   always_comb begin
      result = 64'd0;
      case (op_lat)
         2'd0: result = $signed({{32{a_lat[31]}}, a_lat}) * $signed({{32{b_lat[31]}}, b_lat});
         2'd1: result = {32'd0, a_lat} * {32'd0, b_lat};
         2'd2: begin
            if (b_lat == 32'd0)
               result = {a_lat, 32'hFFFF_FFFF};
            else if (a_lat == 32'h8000_0000 && b_lat == 32'hFFFF_FFFF)
               result = {32'd0, 32'h8000_0000};
            else
               result = {32'(a_s % b_s), 32'(a_s / b_s)};
         end
         default: begin
            if (b_lat == 32'd0)
               result = {a_lat, 32'hFFFF_FFFF};
            else
               result = {a_lat % b_lat, a_lat / b_lat};
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_lat  <= '0;
         b_lat  <= '0;
         op_lat <= '0;
      end else if (load) begin
         a_lat  <= A;
         b_lat  <= B;
         op_lat <= Op[1:0];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         HI <= '0;
         LO <= '0;
      end else if (commit) begin
         HI <= result[63:32];
         LO <= result[31:0];
      end else begin
         if (write_hi) HI <= A;
         if (write_lo) LO <= A;
      end
   end

endmodule
